// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
// In-order queue of outstanding branches between fetch and the branch
// predictor. Fetch pushes {index, predicted direction}; when EX resolves the
// oldest branch the entry is popped and, one cycle later, the predictor write
// port is strobed with the actual outcome. Mispredictions are pulsed and
// counted. Protocol violations (overflow push, resolve while empty) latch a
// sticky error flag.
module branch_resolve_queue #(
  parameter int entry_num  = 256,
  parameter int addr_width = $clog2(entry_num),
  parameter int depth      = 4,
  parameter int cnt_width  = 32
) (
  input  logic                    cpu_clk,
  input  logic                    cpu_rst,
  input  logic                    fetch_br_valid,
  input  logic [addr_width-1:0]   fetch_br_idx,
  input  logic                    fetch_pred_taken,
  input  logic                    ex_br_valid,
  input  logic                    ex_br_taken,
  input  logic                    pipe_flush,
  output logic                    fetch_stall,
  output logic                    predictor_wen,
  output logic [addr_width-1:0]   predictor_waddr,
  output logic                    branch_taken_ex,
  output logic                    mispredict,
  output logic [$clog2(depth):0]  occupancy,
  output logic [cnt_width-1:0]    mispredict_cnt,
  output logic                    q_error
);

  localparam int ptr_w = $clog2(depth);
  localparam int occ_w = ptr_w + 1;
  localparam logic [occ_w-1:0] c_full = occ_w'(depth);

  // Entry storage: predictor index and predicted direction per slot.
  logic [addr_width-1:0] r_mem_idx  [depth];
  logic                  r_mem_pred [depth];

  logic [ptr_w-1:0] r_head;
  logic [ptr_w-1:0] r_tail;
  logic [occ_w-1:0] r_occ;

  logic                  r_wen;
  logic [addr_width-1:0] r_waddr;
  logic                  r_taken;
  logic                  r_mispredict;
  logic [cnt_width-1:0]  r_cnt;
  logic                  r_error;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_push_drop;
  logic                  w_pop_empty;
  logic [addr_width-1:0] w_head_idx;
  logic                  w_head_pred;
  logic                  w_miss;

  assign w_full      = (r_occ == c_full);
  assign w_empty     = (r_occ == '0);
  assign w_pop       = ex_br_valid && !w_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  // A push that coincides with a flush is discarded silently.
  assign w_push      = fetch_br_valid && (!w_full || w_pop) && !pipe_flush;
  assign w_push_drop = fetch_br_valid && w_full && !w_pop && !pipe_flush;
  assign w_pop_empty = ex_br_valid && w_empty;
  assign w_head_idx  = r_mem_idx[r_head];
  assign w_head_pred = r_mem_pred[r_head];
  assign w_miss      = (w_head_pred != ex_br_taken);

  // Write the pushed branch into the tail slot.
  // NOTE: the entry array has no reset; validity is defined purely by the
  // head/tail/occupancy state, so stale contents are never observed. State is
  // updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge cpu_clk) begin
    if (w_push) begin
      r_mem_idx[r_tail]  <= fetch_br_idx;
      r_mem_pred[r_tail] <= fetch_pred_taken;
    end
  end

  // Head/tail pointers and occupancy; flush empties the queue after any pop.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (pipe_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_pop)  r_head <= r_head + ptr_w'(1);
      if (w_push) r_tail <= r_tail + ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + occ_w'(1);
        2'b01:   r_occ <= r_occ - occ_w'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Registered predictor update and misprediction pulse, one cycle after a pop.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_wen        <= 1'b0;
      r_waddr      <= '0;
      r_taken      <= 1'b0;
      r_mispredict <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_wen        <= w_pop;
      r_mispredict <= w_pop && w_miss;
      if (w_pop) begin
        r_waddr <= w_head_idx;
        r_taken <= ex_br_taken;
        if (w_miss && (r_cnt != '1)) r_cnt <= r_cnt + cnt_width'(1);
      end
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_error <= 1'b0;
    end else if (w_push_drop || w_pop_empty) begin
      r_error <= 1'b1;
    end
  end

  assign fetch_stall     = w_full;
  assign predictor_wen   = r_wen;
  assign predictor_waddr = r_waddr;
  assign branch_taken_ex = r_taken;
  assign mispredict      = r_mispredict;
  assign occupancy       = r_occ;
  assign mispredict_cnt  = r_cnt;
  assign q_error         = r_error;

endmodule
